// File: rtl/ga_gen_ctrl_pkg.sv
// rtl/ga_gen_ctrl_pkg.sv - shared GA types: controller states, distance and phase-timer widths
package ga_gen_ctrl_pkg;

  localparam int GA_DIST_W  = 12;
  localparam int GA_TIMER_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEL    = 3'd1,
    ST_XO     = 3'd2,
    ST_MUT    = 3'd3,
    ST_COMMIT = 3'd4,
    ST_FINISH = 3'd5,
    ST_ERR    = 3'd6
  } ga_state_e;

  // Engine phases are the only states where an engine runs and the watchdog counts.
  function automatic logic is_engine_phase(input ga_state_e s);
    return (s == ST_SEL) || (s == ST_XO) || (s == ST_MUT);
  endfunction

endpackage

// File: rtl/ga_phase_timer.sv
// rtl/ga_phase_timer.sv - per-phase watchdog: clear on phase entry, count while an engine runs
module ga_phase_timer
  import ga_gen_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [GA_TIMER_W-1:0] LAST = GA_TIMER_W'(TIMEOUT - 1);

  logic [GA_TIMER_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {GA_TIMER_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  assign expired = inc && (count == LAST);

endmodule

// File: rtl/ga_gen_ctrl.sv
// rtl/ga_gen_ctrl.sv - GA generation sequencer: selection, crossover, mutation, commit per generation
module ga_gen_ctrl
  import ga_gen_ctrl_pkg::*;
#(
  parameter int NUM_GENS = 100,
  parameter int TIMEOUT  = 1024,
  parameter int DIST_W   = GA_DIST_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DIST_W-1:0] target_dist,
  output logic              sel_start,
  input  logic              sel_done,
  input  logic [DIST_W-1:0] sel_best,
  output logic              xo_start,
  input  logic              xo_done,
  output logic              mut_start,
  input  logic              mut_done,
  output logic              pop_we,
  output logic [15:0]       gen_count,
  output logic [DIST_W-1:0] best_dist,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [31:0] NUM_GENS_U = 32'(NUM_GENS);

  ga_state_e         state;
  ga_state_e         state_nxt;
  logic              expired;
  logic              finish_now;
  logic [31:0]       gen_next32;
  logic [15:0]       gen_inc;
  logic [DIST_W-1:0] best_upd;

  assign gen_next32 = {16'd0, gen_count} + 32'd1;
  assign gen_inc    = (gen_count == 16'hFFFF) ? gen_count : gen_count + 16'd1;
  assign best_upd   = (sel_best < best_dist) ? sel_best : best_dist;
  // best_dist already holds this generation's minimum by the time COMMIT is reached.
  assign finish_now = (gen_next32 == NUM_GENS_U) || (best_dist <= target_dist);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_SEL;
      ST_SEL:    if (sel_done) state_nxt = ST_XO;
                 else if (expired) state_nxt = ST_ERR;
      ST_XO:     if (xo_done) state_nxt = ST_MUT;
                 else if (expired) state_nxt = ST_ERR;
      ST_MUT:    if (mut_done) state_nxt = ST_COMMIT;
                 else if (expired) state_nxt = ST_ERR;
      ST_COMMIT: state_nxt = finish_now ? ST_FINISH : ST_SEL;
      ST_FINISH: state_nxt = ST_IDLE;
      ST_ERR:    if (start) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  ga_phase_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_nxt != state),
    .inc    (is_engine_phase(state)),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gen_count <= '0;
      best_dist <= '1;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && (state_nxt == ST_SEL)) begin
        gen_count <= '0;
        best_dist <= '1;
      end
      if ((state == ST_SEL) && sel_done && !abort) begin
        best_dist <= best_upd;
      end
      if (state == ST_COMMIT) begin
        gen_count <= gen_inc;
      end
    end
  end

  assign sel_start = (state == ST_SEL);
  assign xo_start  = (state == ST_XO);
  assign mut_start = (state == ST_MUT);
  assign pop_we    = (state == ST_COMMIT);
  assign done      = (state == ST_FINISH);
  assign error     = (state == ST_ERR);
  assign busy      = (state != ST_IDLE) && (state != ST_ERR);

endmodule

// File: doc/ga_gen_ctrl.md
GA_GEN_CTRL -- requirements
Module: ga_gen_ctrl

Interface
REQ-001 Parameter NUM_GENS, default 100: generations run per start.
REQ-002 Parameter TIMEOUT, default 1024: maximum cycles allowed per phase while waiting for an engine done.
REQ-003 Parameter DIST_W, default 12: distance width.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  run request, sampled in IDLE only.
REQ-007 abort  in  1  cancel the run from any state.
REQ-008 target_dist  in  DIST_W  early-stop threshold.
REQ-009 sel_start  out  1  Selection engine enable, held high for the whole SEL phase.
REQ-010 sel_done  in  1  Selection complete.
REQ-011 sel_best  in  DIST_W  best distance of the current generation, valid when sel_done=1.
REQ-012 xo_start / xo_done  out / in  1 / 1  crossover engine enable/complete, same rules as sel.
REQ-013 mut_start / mut_done  out / in  1 / 1  mutation engine enable/complete, same rules as sel.
REQ-014 pop_we  out  1  one-cycle population-register commit strobe.
REQ-015 gen_count  out  16  generations completed.
REQ-016 best_dist  out  DIST_W  minimum sel_best captured this run.
REQ-017 busy  out  1  high in every state except IDLE and ERR.
REQ-018 done  out  1  one-cycle pulse at run completion.
REQ-019 error  out  1  high while in ERR.

Function
REQ-020 States: IDLE, SEL, XO, MUT, COMMIT, FINISH, ERR; state register is the only sequential control.
REQ-021 Transitions:
- IDLE->SEL on start=1.
- SEL->XO on sel_done; XO->MUT on xo_done; MUT->COMMIT on mut_done.
- COMMIT->FINISH when gen_count+1==NUM_GENS or best_dist<=target_dist (using the updated best value); else COMMIT->SEL.
- FINISH->IDLE.
- ERR->IDLE on start=1.
REQ-022 sel_start, xo_start and mut_start are Moore outputs, equal to (state==SEL/XO/MUT); at most one is high in any cycle.
REQ-023 A done input is acted on in the first cycle it is sampled high in the matching state; done inputs in non-matching states are ignored.
REQ-024 A 16-bit phase timer clears on every phase entry and increments each cycle in SEL/XO/MUT; when timer==TIMEOUT-1 and done is low, next state is ERR.
REQ-025 If done and timeout occur in the same cycle, done wins.
REQ-026 On sel_done in SEL, best_dist <= min(best_dist, sel_best), comparison unsigned.
REQ-027 pop_we=1 exactly in the COMMIT cycle; gen_count increments in the same cycle and saturates at 16'hFFFF.
REQ-028 done=1 exactly in the FINISH cycle.
REQ-029 On IDLE->SEL: gen_count clears to 0 and best_dist sets to all-ones.
REQ-030 start while busy is ignored.
REQ-031 abort=1 forces next state IDLE from any state and outranks done, timeout and start in the same cycle. Already-committed gen_count and best_dist hold; no pop_we or done pulse is issued.
REQ-032 NUM_GENS=1 runs exactly one generation; at least one generation always runs, even if target_dist is all-ones.

Reset
REQ-033 rst_n low asynchronously forces state=IDLE, timer=0, gen_count=0, best_dist=all-ones; all start outputs, pop_we, done and error read 0 while reset is held.
REQ-034 Release of reset mid-run returns to IDLE; the run does not resume.

Structure
REQ-035 The state enumeration, DIST_W and the phase-timer width live in the shared GA package, which is also used by the Selection, crossover and mutation engines.
REQ-036 One sub-module, ga_phase_timer, implements the clear/increment/timeout-compare timer; the state machine and counters stay in ga_gen_ctrl.

Verification
REQ-037 NUM_GENS=3, engines answer done 5 cycles after their start, target_dist=0 -> 3 pop_we pulses, gen_count=3, one done pulse, busy low afterwards.
REQ-038 sel_best sequence 900, 400, 700 with target_dist=500 -> FINISH after generation 2, gen_count=2, best_dist=400.
REQ-039 TIMEOUT=16, xo_done never asserted -> ERR entered 16 cycles after XO entry, error=1, no pop_we; a later start restarts with gen_count=0.
REQ-040 abort in the same cycle as mut_done -> IDLE next cycle, no pop_we, gen_count unchanged.
REQ-041 rst_n driven low mid-SEL, between clock edges -> sel_start falls immediately; after release the block is in IDLE with gen_count=0.
REQ-042 sel_done and timeout in the same cycle -> state XO, not ERR; start pulsed while busy -> no effect.
